// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, instruction-memory request handshake,
// one-entry holding buffer for words returned during a stall, and the IF/ID
// pipeline register that feeds decode.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        RedirectEn,
    input  logic [31:0] RedirectPC,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   hold_instr;
    logic [XLEN-1:0]   hold_pc4;
    logic              hold_valid;

    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   redirect_target;

    // Sequential PC increment (wraps modulo 2^32) and word-aligned redirect target
    assign pc_plus4        = PC + XLEN'(4);
    assign redirect_target = RedirectPC & ~XLEN'(3);

    // Fetch FSM with registered request/address, PC and IF/ID register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state             <= BOOT;
            PC                <= RESET_PC;
            IMemReq           <= 1'b0;
            IMemAddr          <= RESET_PC;
            IF_ID_Instruction <= NOP_INSTR;
            IF_ID_PCPlus4     <= '0;
            IF_ID_Valid       <= 1'b0;
            hold_instr        <= '0;
            hold_pc4          <= '0;
            hold_valid        <= 1'b0;
        end else if (RedirectEn) begin
            // Redirect wins over stall and over any same-cycle response
            PC                <= redirect_target;
            IF_ID_Instruction <= NOP_INSTR;
            IF_ID_Valid       <= 1'b0;
            hold_valid        <= 1'b0;
            IMemReq           <= 1'b1;
            if ((state == FETCH || state == DISCARD) && !IMemReady) begin
                // Outstanding request must finish at its old address; its data is dropped
                state <= DISCARD;
            end else begin
                state    <= FETCH;
                IMemAddr <= redirect_target;
            end
        end else begin
            case (state)
                BOOT: begin
                    state    <= FETCH;
                    IMemReq  <= 1'b1;
                    IMemAddr <= PC;
                end
                FETCH: begin
                    if (IMemReady) begin
                        if (!Stall) begin
                            IF_ID_Instruction <= IMemData;
                            IF_ID_PCPlus4     <= pc_plus4;
                            IF_ID_Valid       <= 1'b1;
                            PC                <= pc_plus4;
                            IMemAddr          <= pc_plus4;
                        end else begin
                            // Park the returned word until decode can accept it
                            hold_instr <= IMemData;
                            hold_pc4   <= pc_plus4;
                            hold_valid <= 1'b1;
                            state      <= HOLD;
                            IMemReq    <= 1'b0;
                        end
                    end else if (!Stall) begin
                        IF_ID_Instruction <= NOP_INSTR;
                        IF_ID_Valid       <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!Stall) begin
                        IF_ID_Instruction <= hold_instr;
                        IF_ID_PCPlus4     <= hold_pc4;
                        IF_ID_Valid       <= hold_valid;
                        hold_valid        <= 1'b0;
                        PC                <= pc_plus4;
                        IMemAddr          <= pc_plus4;
                        state             <= FETCH;
                        IMemReq           <= 1'b1;
                    end
                end
                DISCARD: begin
                    IF_ID_Instruction <= NOP_INSTR;
                    IF_ID_Valid       <= 1'b0;
                    if (IMemReady) begin
                        state    <= FETCH;
                        IMemAddr <= PC;
                    end
                end
                default: begin
                    state   <= BOOT;
                    IMemReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: boot, streaming fetch, wait
// states, stall into the holding buffer, redirect cases, PC wrap, async reset.
module tb_instruction_fetch_stage;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        RedirectEn;
    logic [31:0] RedirectPC;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic [31:0] IMemData;
    logic [31:0] PC;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;

    int n_assert;
    int n_fail;

    instruction_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Stall            (Stall),
        .RedirectEn       (RedirectEn),
        .RedirectPC       (RedirectPC),
        .IMemReq          (IMemReq),
        .IMemAddr         (IMemAddr),
        .IMemReady        (IMemReady),
        .IMemData         (IMemData),
        .PC               (PC),
        .IF_ID_Instruction(IF_ID_Instruction),
        .IF_ID_PCPlus4    (IF_ID_PCPlus4),
        .IF_ID_Valid      (IF_ID_Valid)
    );

    // Instruction memory contents
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0005;
            32'h0000_0004: return 32'h2009_0003;
            32'h0000_0008: return 32'h0109_5020;
            32'h0000_0040: return 32'h8C0B_0000;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign IMemData = mem_word(IMemAddr);

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        Reset      = 1'b0;
        Stall      = 1'b0;
        RedirectEn = 1'b0;
        RedirectPC = 32'h0;
        IMemReady  = 1'b1;

        #3;
        chk("rst_pc",    PC, 32'h0);
        chk("rst_req",   32'(IMemReq), 32'h0);
        chk("rst_instr", IF_ID_Instruction, 32'h0);
        chk("rst_pc4",   IF_ID_PCPlus4, 32'h0);
        chk("rst_valid", 32'(IF_ID_Valid), 32'h0);
        #9 Reset = 1'b1;

        // Boot: request rises one cycle after release
        step();
        chk("boot_req",   32'(IMemReq), 32'h1);
        chk("boot_addr",  IMemAddr, 32'h0);
        chk("boot_valid", 32'(IF_ID_Valid), 32'h0);

        // Zero-wait streaming
        step();
        chk("s0_instr", IF_ID_Instruction, 32'h2008_0005);
        chk("s0_pc4",   IF_ID_PCPlus4, 32'h4);
        chk("s0_valid", 32'(IF_ID_Valid), 32'h1);
        chk("s0_pc",    PC, 32'h4);
        step();
        chk("s1_instr", IF_ID_Instruction, 32'h2009_0003);
        chk("s1_pc4",   IF_ID_PCPlus4, 32'h8);
        step();
        chk("s2_instr", IF_ID_Instruction, 32'h0109_5020);
        chk("s2_pc4",   IF_ID_PCPlus4, 32'hC);
        chk("s2_pc",    PC, 32'hC);

        // Redirect with same-cycle response: back to 4, response dropped
        RedirectEn = 1'b1; RedirectPC = 32'h5;
        step();
        chk("rd1_pc",    PC, 32'h4);
        chk("rd1_valid", 32'(IF_ID_Valid), 32'h0);
        chk("rd1_instr", IF_ID_Instruction, 32'h0);
        chk("rd1_req",   32'(IMemReq), 32'h1);
        chk("rd1_pc4",   IF_ID_PCPlus4, 32'hC);
        RedirectEn = 1'b0; IMemReady = 1'b0;

        // Two wait states at PC=4
        step();
        chk("ws1_addr",  IMemAddr, 32'h4);
        chk("ws1_valid", 32'(IF_ID_Valid), 32'h0);
        step();
        chk("ws2_addr",  IMemAddr, 32'h4);
        chk("ws2_instr", IF_ID_Instruction, 32'h0);
        IMemReady = 1'b1;
        step();
        chk("ws3_instr", IF_ID_Instruction, 32'h2009_0003);
        chk("ws3_pc4",   IF_ID_PCPlus4, 32'h8);
        chk("ws3_valid", 32'(IF_ID_Valid), 32'h1);

        // Stall three cycles while the word at 8 returns
        Stall = 1'b1;
        step();
        chk("st1_req",   32'(IMemReq), 32'h0);
        chk("st1_instr", IF_ID_Instruction, 32'h2009_0003);
        chk("st1_pc",    PC, 32'h8);
        step();
        chk("st2_instr", IF_ID_Instruction, 32'h2009_0003);
        chk("st2_req",   32'(IMemReq), 32'h0);
        step();
        chk("st3_valid", 32'(IF_ID_Valid), 32'h1);
        Stall = 1'b0;
        step();
        chk("rel_instr", IF_ID_Instruction, 32'h0109_5020);
        chk("rel_pc4",   IF_ID_PCPlus4, 32'hC);
        chk("rel_pc",    PC, 32'hC);
        chk("rel_req",   32'(IMemReq), 32'h1);
        IMemReady = 1'b0;

        // Redirect to 0x43 while request to 0xC is pending
        step();
        chk("pend_addr",  IMemAddr, 32'hC);
        chk("pend_valid", 32'(IF_ID_Valid), 32'h0);
        RedirectEn = 1'b1; RedirectPC = 32'h43;
        step();
        chk("dis1_pc",   PC, 32'h40);
        chk("dis1_addr", IMemAddr, 32'hC);
        chk("dis1_req",  32'(IMemReq), 32'h1);
        RedirectEn = 1'b0;
        step();
        chk("dis2_addr",  IMemAddr, 32'hC);
        chk("dis2_valid", 32'(IF_ID_Valid), 32'h0);
        IMemReady = 1'b1;
        step();
        chk("dis3_addr",  IMemAddr, 32'h40);
        chk("dis3_valid", 32'(IF_ID_Valid), 32'h0);
        chk("dis3_instr", IF_ID_Instruction, 32'h0);
        step();
        chk("tgt_instr", IF_ID_Instruction, 32'h8C0B_0000);
        chk("tgt_pc4",   IF_ID_PCPlus4, 32'h44);
        chk("tgt_pc",    PC, 32'h44);

        // Redirect and stall in the same cycle
        RedirectEn = 1'b1; RedirectPC = 32'h100; Stall = 1'b1;
        step();
        chk("rs_pc",    PC, 32'h100);
        chk("rs_valid", 32'(IF_ID_Valid), 32'h0);
        chk("rs_instr", IF_ID_Instruction, 32'h0);
        chk("rs_req",   32'(IMemReq), 32'h1);
        RedirectEn = 1'b0;
        step();
        chk("rsh_req", 32'(IMemReq), 32'h0);
        // Redirect out of HOLD to the top of the address space
        RedirectEn = 1'b1; RedirectPC = 32'hFFFF_FFFE;
        step();
        chk("rh_pc",    PC, 32'hFFFF_FFFC);
        chk("rh_req",   32'(IMemReq), 32'h1);
        chk("rh_valid", 32'(IF_ID_Valid), 32'h0);
        RedirectEn = 1'b0; Stall = 1'b0; IMemReady = 1'b0;
        step();
        chk("rh2_valid", 32'(IF_ID_Valid), 32'h0);
        chk("rh2_addr",  IMemAddr, 32'hFFFF_FFFC);
        IMemReady = 1'b1;

        // PC wrap
        step();
        chk("wr_instr", IF_ID_Instruction, 32'hA5A5_FFFC);
        chk("wr_pc4",   IF_ID_PCPlus4, 32'h0);
        chk("wr_pc",    PC, 32'h0);
        chk("wr_valid", 32'(IF_ID_Valid), 32'h1);
        step();
        chk("wr2_instr", IF_ID_Instruction, 32'h2008_0005);
        chk("wr2_pc",    PC, 32'h4);

        // Async reset in the middle of HOLD
        Stall = 1'b1;
        step();
        chk("h_req", 32'(IMemReq), 32'h0);
        chk("h_pc",  PC, 32'h4);
        #2 Reset = 1'b0;
        #1;
        chk("ar_pc",    PC, 32'h0);
        chk("ar_addr",  IMemAddr, 32'h0);
        chk("ar_req",   32'(IMemReq), 32'h0);
        chk("ar_instr", IF_ID_Instruction, 32'h0);
        chk("ar_pc4",   IF_ID_PCPlus4, 32'h0);
        chk("ar_valid", 32'(IF_ID_Valid), 32'h0);
        Reset = 1'b1; Stall = 1'b0;
        step();
        chk("rb_req",   32'(IMemReq), 32'h1);
        chk("rb_valid", 32'(IF_ID_Valid), 32'h0);
        step();
        chk("rb_instr", IF_ID_Instruction, 32'h2008_0005);
        chk("rb_pc4",   IF_ID_PCPlus4, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
